// File: rtl/sbox_sched.sv
// ============================================================================
// Module      : sbox_sched
// Description : Two-requester, round-robin, time-shared DES S-box engine that
//               walks S1..S8 over one 6-bit lookup bus, one S-box per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// Single DES S-box. TABLE holds 64 nibbles in row-major order, entry 0 in
// the top nibble.
module sbox_lut #(
  parameter logic [255:0] TABLE = '0
) (
  input  logic [5:0] i_idx,
  output logic [3:0] o_val
);
  logic [5:0] w_pos;
  logic [7:0] w_bit;

  // Row comes from the outer bits, column from the middle four.
  assign w_pos = {i_idx[5], i_idx[0], i_idx[4:1]};
  assign w_bit = 8'd255 - {w_pos, 2'b00};
  assign o_val = TABLE[w_bit -: 4];
endmodule

module sbox_sched (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_req_valid,
  input  logic [47:0] i_req_data0,
  input  logic [47:0] i_req_data1,
  output logic [1:0]  o_req_ready,
  output logic        o_rsp_valid,
  output logic        o_rsp_id,
  output logic [31:0] o_rsp_data,
  input  logic        i_rsp_ready
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_step;
  logic        r_rr;
  logic        r_id;
  logic [47:0] r_op;
  logic [31:0] r_result;

  logic [1:0]  w_grant;
  logic        w_accept;
  logic        w_grant_id;
  logic [5:0]  w_op_base;
  logic [4:0]  w_res_base;
  logic [5:0]  w_idx;
  logic [3:0]  w_sbox [8];
  logic [3:0]  w_nib;

  // Step k reads operand bits 47-6k down and writes result bits 31-4k down.
  assign w_op_base  = 6'd47 - ({1'b0, r_step, 2'b00} + {2'b00, r_step, 1'b0});
  assign w_res_base = 5'd31 - {r_step, 2'b00};
  assign w_idx      = r_op[w_op_base -: 6];
  assign w_nib      = w_sbox[r_step];

  sbox_lut #(.TABLE(256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D))
    u_sbox1 (.i_idx(w_idx), .o_val(w_sbox[0]));
  sbox_lut #(.TABLE(256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9))
    u_sbox2 (.i_idx(w_idx), .o_val(w_sbox[1]));
  sbox_lut #(.TABLE(256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C))
    u_sbox3 (.i_idx(w_idx), .o_val(w_sbox[2]));
  sbox_lut #(.TABLE(256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E))
    u_sbox4 (.i_idx(w_idx), .o_val(w_sbox[3]));
  sbox_lut #(.TABLE(256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453))
    u_sbox5 (.i_idx(w_idx), .o_val(w_sbox[4]));
  sbox_lut #(.TABLE(256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D))
    u_sbox6 (.i_idx(w_idx), .o_val(w_sbox[5]));
  sbox_lut #(.TABLE(256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C))
    u_sbox7 (.i_idx(w_idx), .o_val(w_sbox[6]));
  sbox_lut #(.TABLE(256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B))
    u_sbox8 (.i_idx(w_idx), .o_val(w_sbox[7]));

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (&i_req_valid) w_grant = r_rr ? 2'b10 : 2'b01;
        else              w_grant = i_req_valid;
        if (|i_req_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (r_step == 3'd7) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (i_rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept   = |w_grant;
  assign w_grant_id = w_grant[1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_step   <= 3'd0;
      r_rr     <= 1'b0;
      r_id     <= 1'b0;
      r_op     <= 48'd0;
      r_result <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op     <= w_grant_id ? i_req_data1 : i_req_data0;
        r_id     <= w_grant_id;
        r_result <= 32'd0;
        r_step   <= 3'd0;
        r_rr     <= ~w_grant_id;
      end else if (r_state == S_RUN) begin
        r_result[w_res_base -: 4] <= w_nib;
        if (r_step != 3'd7) r_step <= r_step + 3'd1;
      end
    end
  end

  assign o_req_ready = w_grant;
  assign o_rsp_valid = (r_state == S_DONE);
  assign o_rsp_id    = r_id;
  assign o_rsp_data  = r_result;
endmodule

`default_nettype wire
